inst_decode: RTL

INST_DECODE -- requirements
Module: inst_decode

---
 rtl/inst_decode_if.sv | 37 +++
 rtl/inst_decode.sv | 79 +++++++
 2 files changed

// File: rtl/inst_decode_if.sv
// inst_decode_if: decode-stage bundle between fetch, EX hazard info and the decoded output register.
// The master side drives the fetch/EX inputs; the slave side is the decoder.
interface inst_decode_if;
   logic        stall;
   logic        flush;
   logic [31:0] inst;
   logic [63:0] PC_i;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        hazard_stall;
   logic        valid;
   logic [63:0] PC_o;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [63:0] imm;
   logic        alu_src_imm;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic        jump;
   logic        illegal;
   modport master (
      output stall, flush, inst, PC_i, ex_rd, ex_mem_read,
      input  hazard_stall, valid, PC_o, opcode, funct3, funct7_5, rs1, rs2, rd, imm,
             alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal
   );
   modport slave (
      input  stall, flush, inst, PC_i, ex_rd, ex_mem_read,
      output hazard_stall, valid, PC_o, opcode, funct3, funct7_5, rs1, rs2, rd, imm,
             alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal
   );
endinterface

// File: rtl/inst_decode.sv
// inst_decode: RV64 decode stage with load-use hazard detection and a one-cycle registered output bundle.
// Bubbles (flush or hazard) load all-zero, so no control flag can leak out of a bubble.
module inst_decode (
   input  logic          CLK,
   input  logic          reset,
   inst_decode_if.slave  bus
);
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OPIMMW = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPW    = 7'b0111011;

   logic [31:0]  w_i;
   logic [6:0]   w_op;
   logic         w_load, w_opimm, w_opimmw, w_jalr, w_store, w_branch;
   logic         w_lui, w_auipc, w_jal, w_alu, w_aluw, w_legal;
   logic [63:0]  w_imm;
   logic         w_rs1_use, w_rs2_use, w_hazard, w_reg_write, w_alu_src_imm;
   logic [161:0] w_next;
   logic [161:0] r_out;

   assign w_i      = bus.inst;
   assign w_op     = w_i[6:0];
   assign w_load   = w_op == OP_LOAD;
   assign w_opimm  = w_op == OP_OPIMM;
   assign w_opimmw = w_op == OP_OPIMMW;
   assign w_jalr   = w_op == OP_JALR;
   assign w_store  = w_op == OP_STORE;
   assign w_branch = w_op == OP_BRANCH;
   assign w_lui    = w_op == OP_LUI;
   assign w_auipc  = w_op == OP_AUIPC;
   assign w_jal    = w_op == OP_JAL;
   assign w_alu    = w_op == OP_OP;
   assign w_aluw   = w_op == OP_OPW;
   // every listed opcode ends in 2'b11, so a match also implies inst[1:0] == 2'b11
   assign w_legal  = w_load | w_opimm | w_opimmw | w_jalr | w_store | w_branch |
                     w_lui | w_auipc | w_jal | w_alu | w_aluw;

   always_comb begin
      w_imm = (w_load | w_opimm | w_opimmw | w_jalr) ? {{52{w_i[31]}}, w_i[31:20]} :
              w_store                                 ? {{52{w_i[31]}}, w_i[31:25], w_i[11:7]} :
              w_branch                                ? {{51{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0} :
              (w_lui | w_auipc)                       ? {{32{w_i[31]}}, w_i[31:12], 12'b0} :
              w_jal                                   ? {{43{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0} :
                                                        64'd0;
   end

   assign w_alu_src_imm = w_legal & ~(w_alu | w_aluw | w_branch);
   assign w_reg_write   = (w_load | w_opimm | w_opimmw | w_alu | w_aluw | w_lui | w_auipc | w_jal | w_jalr) &
                          (w_i[11:7] != 5'd0);
   assign w_rs1_use     = w_legal & ~(w_lui | w_auipc | w_jal);
   assign w_rs2_use     = w_alu | w_aluw | w_store | w_branch;
   assign w_hazard      = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                          ((w_rs1_use & (bus.ex_rd == w_i[19:15])) | (w_rs2_use & (bus.ex_rd == w_i[24:20])));
   assign bus.hazard_stall = w_hazard;

   assign w_next = {1'b1, bus.PC_i, w_op, w_i[14:12], w_i[30], w_i[19:15], w_i[24:20], w_i[11:7], w_imm,
                    w_alu_src_imm, w_reg_write, w_load, w_store, w_branch, w_jal | w_jalr, ~w_legal};

   // flush beats stall; a hazard only inserts a bubble when the stage is free to advance
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         r_out <= '0;
      else if (bus.flush || (!bus.stall && w_hazard))
         r_out <= '0;
      else if (!bus.stall)
         r_out <= w_next;
   end

   assign {bus.valid, bus.PC_o, bus.opcode, bus.funct3, bus.funct7_5, bus.rs1, bus.rs2, bus.rd, bus.imm,
           bus.alu_src_imm, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump, bus.illegal} = r_out;
endmodule
